// File: rtl/muldiv_sequencer.sv
`timescale 1ns/1ps
// muldiv_sequencer: multi-cycle RV32M execution unit sitting beside the EX-stage ALU.
// It sequences an iterative shift-add multiplier and a restoring divider, one bit per
// cycle over XLEN cycles. It stalls upstream stages while busy and returns the result
// together with its destination tag.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        EX holds a valid M-extension op this cycle
//   flush        pipeline redirect; aborts any op in flight
//   op           funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rs1, rs2     operands, sampled only when the op is accepted
//   rd_tag_in    destination register index
//   stall        freeze IF/ID/EX (combinational)
//   busy         sequencer not idle
//   result_valid one-cycle qualifier for result/rd_tag_out
//   result       instruction result, held between ops
//   rd_tag_out   tag of the op that produced result
module muldiv_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] rd_tag_in,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] rd_tag_out
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    // Multiply: product register, multiplier in the low half shifting out.
    // Divide: {partial remainder, dividend/quotient} shifting left.
    logic [ACC_W-1:0]   acc;
    logic [XLEN-1:0]    opnd;      // multiplicand or divisor magnitude
    logic [2:0]         op_q;
    logic               neg_q;     // negate product / quotient
    logic               neg_r;     // remainder follows dividend sign
    logic [TAG_W-1:0]   tag_q;

    // Operand decode for the op being offered in IDLE.
    logic               in_div;
    logic               in_rem;
    logic               in_sign_a;
    logic               in_sign_b;
    logic               in_a_neg;
    logic               in_b_neg;
    logic               in_fast;
    logic [XLEN-1:0]    in_a_mag;
    logic [XLEN-1:0]    in_b_mag;
    logic [XLEN-1:0]    in_fast_res;

    always_comb begin
        in_div      = op[2];
        in_rem      = op[2] & op[1];
        in_sign_a   = in_div ? ~op[0] : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10));
        in_sign_b   = in_div ? ~op[0] : (op[1:0] == 2'b01);
        in_a_neg    = in_sign_a & rs1[XLEN-1];
        in_b_neg    = in_sign_b & rs2[XLEN-1];
        in_a_mag    = in_a_neg ? -rs1 : rs1;
        in_b_mag    = in_b_neg ? -rs2 : rs2;
        in_fast     = 1'b0;
        in_fast_res = '0;
        // Divide by zero and signed overflow resolve without iterating.
        if (in_div) begin
            if (rs2 == '0) begin
                in_fast     = 1'b1;
                in_fast_res = in_rem ? rs1 : '1;
            end else if (~op[0] && (rs1 == MIN_NEG) && (rs2 == '1)) begin
                in_fast     = 1'b1;
                in_fast_res = in_rem ? '0 : MIN_NEG;
            end
        end
    end

    // One iteration of the active datapath plus sign fix-up of its outcome.
    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      div_shift;
    logic               div_ge;
    logic [XLEN-1:0]    div_rem;
    logic [ACC_W-1:0]   acc_nxt;
    logic [ACC_W-1:0]   prod_fix;
    logic [XLEN-1:0]    quot_fix;
    logic [XLEN-1:0]    rem_fix;
    logic [XLEN-1:0]    calc_res;

    always_comb begin
        mul_sum   = {1'b0, acc[ACC_W-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        div_shift = {acc[ACC_W-1:XLEN], acc[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        // When the trial subtract succeeds the difference always fits in XLEN bits.
        div_rem   = div_ge ? (div_shift[XLEN-1:0] - opnd) : div_shift[XLEN-1:0];
        if (op_q[2]) begin
            acc_nxt = {div_rem, acc[XLEN-2:0], div_ge};
        end else begin
            acc_nxt = {mul_sum, acc[XLEN-1:1]};
        end
        prod_fix = neg_q ? -acc_nxt : acc_nxt;
        quot_fix = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem_fix  = neg_r ? -acc_nxt[ACC_W-1:XLEN] : acc_nxt[ACC_W-1:XLEN];
        if (op_q[2]) begin
            calc_res = op_q[1] ? rem_fix : quot_fix;
        end else if (op_q[1:0] == 2'b00) begin
            calc_res = prod_fix[XLEN-1:0];
        end else begin
            calc_res = prod_fix[ACC_W-1:XLEN];
        end
    end

    // Sequencer and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            acc        <= '0;
            opnd       <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            tag_q      <= '0;
            result     <= '0;
            rd_tag_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_q  <= op;
                        tag_q <= rd_tag_in;
                        neg_q <= in_a_neg ^ in_b_neg;
                        neg_r <= in_a_neg;
                        if (in_fast) begin
                            result     <= in_fast_res;
                            rd_tag_out <= rd_tag_in;
                            state      <= S_DONE;
                        end else begin
                            acc   <= {{XLEN{1'b0}}, (in_div ? in_a_mag : in_b_mag)};
                            opnd  <= in_div ? in_b_mag : in_a_mag;
                            cnt   <= CNT_W'(XLEN);
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt - CNT_W'(1);
                        // Last iteration: fix-up lands in result as DONE is entered.
                        if (cnt == CNT_W'(1)) begin
                            result     <= calc_res;
                            rd_tag_out <= tag_q;
                            state      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // stall must drop in the same cycle the op is offered with a flush, hence combinational.
    assign stall        = ((state == S_IDLE) && start && !flush) || (state == S_CALC);
    assign busy         = (state != S_IDLE);
    assign result_valid = (state == S_DONE) && !flush;

endmodule
